// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU: single-cycle ADD/SUB/AND/ORR/PASS plus iterative
// shift-add MUL and restoring UDIV, with registered result and NZCV flags.
`ifndef WORD
`define WORD 32
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SUB  4'b0001
`define ALU_AND  4'b0010
`define ALU_ORR  4'b0011
`define ALU_PASS 4'b0100
`define ALU_MUL  4'b0101
`define ALU_UDIV 4'b0110
`endif

module multicycle_alu #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_control,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic [1:0]         state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic [2*WIDTH-1:0] acc_r, acc_nxt_s;
  logic [WIDTH-1:0]   opnd_r, opnd_nxt_s;
  logic               done_s, carry_s, ovf_s, dbz_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH:0]     add_s, sub_s, mul_sum_s, div_shift_s, div_diff_s;

  assign ready = (state_r == IDLE);
  assign add_s = {1'b0, a_in} + {1'b0, b_in};
  assign sub_s = {1'b0, a_in} - {1'b0, b_in};
  // acc_r holds {product-high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
  assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

  // Next-state, iteration step and completion result/flags
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    opnd_nxt_s  = opnd_r;
    done_s      = 1'b0;
    res_s       = {WIDTH{1'b0}};
    carry_s     = 1'b0;
    ovf_s       = 1'b0;
    dbz_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          cnt_nxt_s = {CW{1'b0}};
          case (alu_control)
            `ALU_ADD: begin
              done_s  = 1'b1;
              res_s   = add_s[WIDTH-1:0];
              carry_s = add_s[WIDTH];
              ovf_s   = add_ovf(a_in[WIDTH-1], b_in[WIDTH-1], add_s[WIDTH-1]);
            end
            `ALU_SUB: begin
              done_s  = 1'b1;
              res_s   = sub_s[WIDTH-1:0];
              carry_s = ~sub_s[WIDTH];
              ovf_s   = sub_ovf(a_in[WIDTH-1], b_in[WIDTH-1], sub_s[WIDTH-1]);
            end
            `ALU_AND: begin
              done_s = 1'b1;
              res_s  = a_in & b_in;
            end
            `ALU_ORR: begin
              done_s = 1'b1;
              res_s  = a_in | b_in;
            end
            `ALU_PASS: begin
              done_s = 1'b1;
              res_s  = b_in;
            end
            `ALU_MUL: begin
              state_nxt_s = MUL;
              acc_nxt_s   = {{WIDTH{1'b0}}, b_in};
              opnd_nxt_s  = a_in;
            end
            `ALU_UDIV: begin
              if (b_in == {WIDTH{1'b0}}) begin
                done_s = 1'b1;
                res_s  = {WIDTH{1'b1}};
                dbz_s  = 1'b1;
              end else begin
                state_nxt_s = DIV;
                acc_nxt_s   = {{WIDTH{1'b0}}, a_in};
                opnd_nxt_s  = b_in;
              end
            end
            default: done_s = 1'b1;
          endcase
        end else begin
          done_s = 1'b0;
        end
      end
      MUL: begin
        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        acc_nxt_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[2*WIDTH-1:1]};
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
          res_s       = acc_nxt_s[WIDTH-1:0];
          ovf_s       = |acc_nxt_s[2*WIDTH-1:WIDTH];
        end else begin
          state_nxt_s = MUL;
        end
      end
      DIV: begin
        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        acc_nxt_s = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                      : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
          res_s       = acc_nxt_s[WIDTH-1:0];
        end else begin
          state_nxt_s = DIV;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and output registers; flags change only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      valid_out   <= 1'b0;
      alu_result  <= {WIDTH{1'b0}};
      zero        <= 1'b1;
      negative    <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      acc_r     <= acc_nxt_s;
      opnd_r    <= opnd_nxt_s;
      valid_out <= done_s;
      if (done_s) begin
        alu_result  <= res_s;
        zero        <= (res_s == {WIDTH{1'b0}});
        negative    <= res_s[WIDTH-1];
        carry       <= carry_s;
        overflow    <= ovf_s;
        div_by_zero <= dbz_s;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu at WIDTH 32 and 64: vector table, directed multi-cycle
// sequences and random operations checked against an arithmetic reference model.
module tb_multicycle_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_PASS = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_UDIV = 4'd6;
  localparam logic [3:0] OP_BAD  = 4'hF;

  // flags are packed {zero, negative, carry, overflow, div_by_zero}
  typedef struct packed { logic vo; logic rdy; logic [63:0] r; logic [4:0] f; } obs_t;
  typedef struct { int w; logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] r; logic [4:0] f; } vec_t;
  typedef struct { logic [63:0] r; logic [4:0] f; int lat; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic v32, v64;
  logic [3:0] op;
  logic [63:0] a, b;
  logic rdy32, vo32, z32, n32, c32, o32, d32;
  logic [31:0] r32;
  logic rdy64, vo64, z64, n64, c64, o64, d64;
  logic [63:0] r64;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .valid_in(v32), .ready(rdy32), .a_in(a[31:0]), .b_in(b[31:0]),
    .alu_control(op), .valid_out(vo32), .alu_result(r32), .zero(z32), .negative(n32),
    .carry(c32), .overflow(o32), .div_by_zero(d32));

  multicycle_alu #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .valid_in(v64), .ready(rdy64), .a_in(a), .b_in(b),
    .alu_control(op), .valid_out(vo64), .alu_result(r64), .zero(z64), .negative(n64),
    .carry(c64), .overflow(o64), .div_by_zero(d64));

  function automatic obs_t sample(input int w);
    obs_t o;
    if (w == 32) begin
      o.vo = vo32; o.rdy = rdy32; o.r = {32'd0, r32}; o.f = {z32, n32, c32, o32, d32};
    end else begin
      o.vo = vo64; o.rdy = rdy64; o.r = r64; o.f = {z64, n64, c64, o64, d64};
    end
    return o;
  endfunction

  function automatic logic signed [129:0] as_signed(input logic [63:0] x, input int w);
    logic signed [129:0] t;
    t = $signed({66'd0, x});
    if (x[w-1]) t = t - (130'sd1 <<< w);
    return t;
  endfunction

  // lat = negedges from acceptance until valid_out is seen (1 for single-cycle ops)
  function automatic exp_t model(input int w, input logic [3:0] o, input logic [63:0] xi, input logic [63:0] yi);
    exp_t e;
    logic [63:0] mask, x, y;
    logic [127:0] wide;
    logic signed [129:0] s, lim;
    logic c, v, d;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = xi & mask; y = yi & mask;
    c = 1'b0; v = 1'b0; d = 1'b0; e.lat = 1; wide = 128'd0;
    lim = 130'sd1 <<< (w - 1);
    case (o)
      OP_ADD: begin
        wide = {64'd0, x} + {64'd0, y};
        c = wide[w];
        s = as_signed(x, w) + as_signed(y, w);
        v = (s >= lim) || (s < -lim);
      end
      OP_SUB: begin
        wide = {64'd0, x} - {64'd0, y};
        c = (x >= y);
        s = as_signed(x, w) - as_signed(y, w);
        v = (s >= lim) || (s < -lim);
      end
      OP_AND:  wide = {64'd0, x & y};
      OP_ORR:  wide = {64'd0, x | y};
      OP_PASS: wide = {64'd0, y};
      OP_MUL: begin
        wide = {64'd0, x} * {64'd0, y};
        v = ((wide >> w) != 128'd0);
        e.lat = w + 1;
      end
      OP_UDIV: begin
        if (y == 64'd0) begin
          wide = {64'd0, mask};
          d = 1'b1;
        end else begin
          wide = {64'd0, x / y};
          e.lat = w + 1;
        end
      end
      default: wide = 128'd0;
    endcase
    e.r = wide[63:0] & mask;
    e.f = {e.r == 64'd0, e.r[w-1], c, v, d};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_valid(input int w, input logic on);
    v32 = on && (w == 32);
    v64 = on && (w == 64);
  endtask

  // Issue one request at the current negedge and wait (bounded) for its completion
  task automatic run_op(input string name, input int w, input logic [3:0] o,
                        input logic [63:0] x, input logic [63:0] y, output obs_t res);
    exp_t e;
    obs_t s;
    int cyc, busy_low;
    e = model(w, o, x, y);
    s = sample(w);
    chk({name, " ready_before"}, 64'(s.rdy), 64'd1);
    op = o; a = x; b = y; set_valid(w, 1'b1);
    @(posedge clk); #1;
    set_valid(w, 1'b0);
    cyc = 0; busy_low = 0;
    do begin
      @(negedge clk); cyc++;
      s = sample(w);
      if (!s.vo && !s.rdy) busy_low++;
    end while (!s.vo && cyc < 200);
    res = s;
    chk({name, " latency"}, 64'(cyc), 64'(e.lat));
    chk({name, " ready_low_cycles"}, 64'(busy_low), 64'(e.lat - 1));
    chk({name, " ready_at_done"}, 64'(s.rdy), 64'd1);
    chk({name, " result"}, s.r, e.r);
    chk({name, " flags"}, 64'(s.f), 64'(e.f));
    @(negedge clk);
    s = sample(w);
    chk({name, " valid_out_pulse"}, 64'(s.vo), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    obs_t s;
    int cyc, seen;
    logic [3:0] ro;
    int rw;
    logic [63:0] rx, ry;

    tbl[0]  = '{64, OP_ADD,  64'd10, 64'd15, 64'd25, 5'b00000};
    tbl[1]  = '{64, OP_SUB,  64'd10, 64'd15, 64'hFFFF_FFFF_FFFF_FFFB, 5'b01000};
    tbl[2]  = '{32, OP_SUB,  64'd65536, 64'd65536, 64'd0, 5'b10100};
    tbl[3]  = '{32, OP_ADD,  64'h7FFF_FFFF, 64'd1, 64'h8000_0000, 5'b01010};
    tbl[4]  = '{32, OP_ADD,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 5'b01100};
    tbl[5]  = '{32, OP_SUB,  64'h8000_0000, 64'd1, 64'h7FFF_FFFF, 5'b00110};
    tbl[6]  = '{32, OP_AND,  64'd10, 64'd15, 64'd10, 5'b00000};
    tbl[7]  = '{32, OP_ORR,  64'hF0F0_0000, 64'h0000_0F0F, 64'hF0F0_0F0F, 5'b01000};
    tbl[8]  = '{32, OP_PASS, 64'd123, 64'd15, 64'd15, 5'b00000};
    tbl[9]  = '{32, OP_BAD,  64'd5, 64'd6, 64'd0, 5'b10000};
    tbl[10] = '{32, OP_UDIV, 64'd5, 64'd0, 64'hFFFF_FFFF, 5'b01001};
    tbl[11] = '{32, OP_AND,  64'd10, 64'd15, 64'd10, 5'b00000};
    tbl[12] = '{64, OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'b10100};
    tbl[13] = '{64, OP_SUB,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000};

    // reset, with a request pending on the same edges (reset must win)
    rst = 1'b1; op = OP_ADD; a = 64'd1; b = 64'd2; v32 = 1'b1; v64 = 1'b1;
    repeat (2) @(negedge clk);
    s = sample(32);
    chk("reset32 ready", 64'(s.rdy), 64'd1);
    chk("reset32 valid_out", 64'(s.vo), 64'd0);
    chk("reset32 result", s.r, 64'd0);
    chk("reset32 flags", 64'(s.f), 64'(5'b10000));
    s = sample(64);
    chk("reset64 result", s.r, 64'd0);
    chk("reset64 flags", 64'(s.f), 64'(5'b10000));
    rst = 1'b0; set_valid(32, 1'b0);
    @(negedge clk);
    chk("idle no valid_out", 64'(vo32 | vo64), 64'd0);

    // back-to-back single-cycle vectors: one request per cycle
    for (int i = 0; i < 14; i++) begin
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; set_valid(tbl[i].w, 1'b1);
      @(negedge clk);
      s = sample(tbl[i].w);
      chk($sformatf("vec%0d valid_out", i), 64'(s.vo), 64'd1);
      chk($sformatf("vec%0d result", i), s.r, tbl[i].r);
      chk($sformatf("vec%0d flags", i), 64'(s.f), 64'(tbl[i].f));
    end
    set_valid(32, 1'b0);
    @(negedge clk);
    chk("after table no valid_out", 64'(vo32 | vo64), 64'd0);

    // directed multi-cycle cases
    run_op("mul_64k_sq", 32, OP_MUL, 64'd65536, 64'd65536, s);
    chk("mul_64k_sq hand", {s.r[58:0], s.f}, {59'd0, 5'b10010});
    run_op("mul_1000_sq", 32, OP_MUL, 64'd1000, 64'd1000, s);
    chk("mul_1000_sq hand", {s.r[58:0], s.f}, {59'd1000000, 5'b00000});
    run_op("div_100_7", 32, OP_UDIV, 64'd100, 64'd7, s);
    chk("div_100_7 hand", {s.r[58:0], s.f}, {59'd14, 5'b00000});
    run_op("div_by_0", 32, OP_UDIV, 64'd5, 64'd0, s);
    chk("div_by_0 hand", {s.r[58:0], s.f}, {59'h0_FFFF_FFFF, 5'b01001});
    run_op("and_after_dbz", 32, OP_AND, 64'd10, 64'd15, s);
    chk("and_after_dbz hand", {s.r[58:0], s.f}, {59'd10, 5'b00000});
    run_op("mul64", 64, OP_MUL, 64'h1_0000_0001, 64'd3, s);
    run_op("mul64_ovf", 64, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, s);
    run_op("div64", 64, OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, s);
    run_op("div_small_big", 32, OP_UDIV, 64'd3, 64'hFFFF_FFFF, s);

    // reset ten cycles into a MUL
    op = OP_MUL; a = 64'd1000; b = 64'd1000; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (vo32) seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s = sample(32);
    chk("rst_mid ready", 64'(s.rdy), 64'd1);
    chk("rst_mid valid_out", 64'(s.vo), 64'd0);
    chk("rst_mid result", s.r, 64'd0);
    chk("rst_mid flags", 64'(s.f), 64'(5'b10000));
    repeat (40) begin
      @(negedge clk);
      if (vo32) seen++;
    end
    chk("rst_mid no valid_out", 64'(seen), 64'd0);
    run_op("pass_after_rst", 32, OP_PASS, 64'd99, 64'd15, s);
    chk("pass_after_rst hand", s.r, 64'd15);

    // busy protection: valid_in held with changing operands during a UDIV
    op = OP_UDIV; a = 64'd1000; b = 64'd7; v32 = 1'b1;
    @(posedge clk); #1;
    cyc = 0; seen = 0;
    do begin
      @(negedge clk); cyc++;
      if (!vo32) begin
        op = 4'($urandom_range(0, 6)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      end
    end while (!vo32 && cyc < 200);
    chk("busy latency", 64'(cyc), 64'd33);
    chk("busy result", {32'd0, r32}, 64'd142);
    op = OP_ADD; a = 64'd3; b = 64'd4;
    @(negedge clk);
    chk("accept_at_done valid_out", 64'(vo32), 64'd1);
    chk("accept_at_done result", {32'd0, r32}, 64'd7);
    v32 = 1'b0;
    @(negedge clk);
    chk("accept_at_done pulse", 64'(vo32), 64'd0);

    // random operations against the model
    for (int i = 0; i < 150; i++) begin
      rw = ($urandom_range(0, 1) == 0) ? 32 : 64;
      ro = 4'($urandom_range(0, 7));
      if (ro == 4'd7) ro = 4'($urandom_range(7, 15));
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ry = 64'd0;
      else if ($urandom_range(0, 3) == 0) ry = 64'($urandom_range(1, 255));
      run_op($sformatf("rand%0d", i), rw, ro, rx, ry, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
